// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_n slice.
//   STREAM_MUX_MODE_SEL / STREAM_MUX_MODE_RR : values for the MODE parameter.
//   clog2_min1(n)                            : ceil(log2(n)), never below 1; sizes the select.
package stream_mux_pkg;

  localparam int unsigned STREAM_MUX_MODE_SEL = 0;
  localparam int unsigned STREAM_MUX_MODE_RR  = 1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req     in  N   request vector
//   ptr     in  SW  search start index (always < N)
//   gnt_idx out SW  first requesting index at or after ptr, wrapping N-1 -> 0;
//                   equals ptr when nothing requests
//   any     out 1   at least one request present
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest request overwrites last.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = ptr;
    any     = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(N)) begin
        idx = idx - int'(N);
      end
      if (req[idx]) begin
        gnt_idx = SW'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 valid/ready stream multiplexer with a registered output stage.
// Channel choice is either the sel input (MODE 0) or round-robin over valid inputs (MODE 1).
// Optional feature macro: STREAM_MUX_SEL_CHECK_EN -- registers sel_err for an out-of-range
// (or, in simulation, X/Z) sel in MODE 0; without it sel_err is tied low.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   in_data    N*W  channel i at [i*W +: W]
//   in_valid   N    per-channel valid
//   in_ready   N    per-channel ready, combinational, at most one bit set
//   sel        SW   channel select (MODE 0 only)
//   out_data   W    registered output word
//   out_valid  1    registered output valid
//   out_ready  1    consumer ready
//   sel_err    1    registered out-of-range select flag
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = STREAM_MUX_MODE_SEL,
  localparam int unsigned SW  = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  localparam logic [SW:0] NLim = (SW + 1)'(N);

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic [SW-1:0] cand;
  logic          cand_ok;
  logic          cand_valid;
  logic [W-1:0]  cand_data;
  logic          ready_en;
  logic          grant;
  logic          sel_in_range;
  logic          sel_ok;
  logic [SW-1:0] rr_idx;

  assign load = !out_valid_q || out_ready;

  // Range check only exists when N leaves unused codes in sel.
  if (N == (1 << SW)) begin : g_sel_full
    assign sel_in_range = 1'b1;
  end else begin : g_sel_part
    assign sel_in_range = ({1'b0, sel} < NLim);
  end

`ifdef STREAM_MUX_SEL_CHECK_EN
  logic sel_x;
  logic sel_err_q, sel_err_d;

`ifndef SYNTHESIS
  assign sel_x = $isunknown(sel);
`else
  assign sel_x = 1'b0;
`endif

  assign sel_ok    = sel_in_range && !sel_x;
  assign sel_err_d = (MODE == STREAM_MUX_MODE_SEL) && load && !sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_ok  = sel_in_range;
  assign sel_err = 1'b0;
`endif

  if (MODE == STREAM_MUX_MODE_RR) begin : g_rr
    logic unused_rr;
    logic rr_any;

    rr_pick #(
      .N(N)
    ) u_rr_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .any     (rr_any)
    );

    // With nothing valid the picker parks on ptr, so in_ready still offers that channel.
    assign cand      = rr_idx;
    assign cand_ok   = 1'b1;
    assign unused_rr = ^{sel, sel_ok, rr_any};
  end else begin : g_sel
    logic unused_ptr;
    assign rr_idx     = '0;
    assign cand       = sel;
    assign cand_ok    = sel_ok;
    assign unused_ptr = ^{ptr_q, rr_idx};
  end

  // Decode by comparison so an out-of-range cand never indexes past the vectors.
  always_comb begin
    cand_valid = 1'b0;
    cand_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cand == SW'(i)) begin
        cand_valid = in_valid[i];
        cand_data  = in_data[i*W +: W];
      end
    end
  end

  assign ready_en = load && cand_ok && !rst;
  assign grant    = ready_en && cand_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_ready[i] = ready_en && (cand == SW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    ptr_d       = ptr_q;
    if (grant) begin
      out_data_d  = cand_data;
      out_valid_d = 1'b1;
      if (MODE == STREAM_MUX_MODE_RR) begin
        ptr_d = (cand == SW'(N - 1)) ? '0 : cand + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-to-1 streaming multiplexer: the clocked successor to the team's 4-to-1 combinational mux. It selects one of N valid/ready input channels, either by an explicit `sel` input or by round-robin arbitration, and delivers the chosen word through a registered output stage with full backpressure. It sits between multiple producers and a single consumer wherever channel merging needs handshaking and throughput of one word per cycle.

## Interface
- `N`, default 4: number of input channels, 2..16; need not be a power of two.
- `W`, default 8: data width per channel.
- `MODE`, default 0: 0 = select-driven, 1 = round-robin; fixed at elaboration.
- `SW` (localparam): max(1, $clog2(N)), width of `sel`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  N*W: channel i occupies bits [i*W +: W].
- `in_valid`  in  N: per-channel valid.
- `in_ready`  out  N: per-channel ready; combinational.
- `sel`  in  SW: channel select; used only when MODE = 0.
- `out_data`  out  W: registered output word.
- `out_valid`  out  1: registered output valid.
- `out_ready`  in  1: consumer ready.
- `sel_err`  out  1: registered out-of-range select flag (see Configuration).

## Operation
- `load = !out_valid || out_ready`: the output register is empty, or is being drained this cycle.
- **Candidate channel `c`:**
  - MODE 0: `c = sel`.
  - MODE 1: first i with `in_valid[i]` set, searching from `ptr` upward and wrapping at N-1 to 0.
- **Grant:** occurs when `load`, `in_valid[c]`, `c < N`, and not `rst` all hold.
- **`in_ready`:** `in_ready[i]` = 1 only for i = c, and only when `load`, `c < N`, and not `rst` hold. It does not depend on `in_valid` (AXI-style), and at most one bit is set.
- **On grant:** `out_data <= in_data[c]`, `out_valid <= 1`. In MODE 1, `ptr <= (c+1) mod N`.
- **`out_ready` without grant:** `out_valid <= 0`, and `out_data` holds its last value.
- **Stall (`out_valid && !out_ready`):** `out_data` and `out_valid` hold, all `in_ready` = 0, and `ptr` holds.
- **MODE 1 with no valid input:** no grant, `ptr` holds.
- **MODE 0 with `sel >= N`** (only possible when N is not a power of two): no grant, all `in_ready` = 0.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `sel_err` = 0, `ptr` = 0. `in_ready` is forced to 0 during any cycle with `rst` high.
- **Latency:** input accepted at edge k gives `out_valid` high after edge k.
- **Throughput:** one word per cycle with `out_ready` held high (simultaneous drain and load).
- **`sel` sampling:** sampled in the same cycle as the handshake; changing `sel` while stalled causes no side effects.
- **Reset mid-operation:** a held, undelivered word is discarded; `ptr` returns to 0.
- **Round-robin fairness:** with all N channels continuously valid and `out_ready` = 1, the grant order is 0, 1, …, N-1, 0, … Each requesting channel waits at most N-1 grants.

## Configuration
- Macro: `STREAM_MUX_SEL_CHECK_EN`.
- **Defined:**
  - In MODE 0, `sel_err <= 1` for one cycle, on the edge after any cycle where `load` = 1 and `sel >= N`.
  - In simulation, a `sel` containing X/Z is treated as out-of-range and also flags.
  - No grant occurs in either case.
- **Undefined:**
  - `sel_err` is tied to 0; an out-of-range `sel` still grants nothing.
  - No X-check logic is compiled.
- MODE 1 never asserts `sel_err`.

## Structure
- **Package `stream_mux_pkg`:** mode constants `STREAM_MUX_MODE_SEL` = 0 and `STREAM_MUX_MODE_RR` = 1, and a function `clog2_min1` used to derive `SW`.
- **Sub-module `rr_pick`:**
  - Combinational; parameter N.
  - Inputs: `req[N]`, `ptr[SW]`. Outputs: `gnt_idx[SW]`, `any`.
  - Finds the first request at or after `ptr`, with wrap-around.
  - Instantiated only when MODE = 1 (generate).

## Test plan
1. **MODE 0 select sweep:** N=4, W=1, all inputs valid with data bits 1,0,1,1 (ch0..ch3, i.e. nibble 4'b1101), `out_ready` = 1, `sel` = 0,1,2,3 on successive cycles. Expect `out_data` = 1,0,1,1, each one cycle later, with `out_valid` high continuously.
2. **Backpressure:** N=4, W=8. Accept 0xA5 from channel 2, then hold `out_ready` = 0 for 3 cycles with channel 2 still valid. Expect `out_data` = 0xA5 held, all `in_ready` = 0, and exactly one further transfer once `out_ready` returns to 1.
3. **Round-robin fairness:** MODE 1, N=3, all valid with data 0x10/0x20/0x30, `out_ready` = 1. Expect the sequence 0x10, 0x20, 0x30, 0x10. Then drop channel 1's valid; expect 0x30, 0x10, 0x30 in alternation.
4. **Out-of-range select:** MODE 0, N=3, `sel` = 3 for one cycle, macro defined. Expect no grant, `in_ready` = 0, and `sel_err` = 1 for exactly one cycle. Without the macro, expect `sel_err` to stay 0.
5. **Reset mid-operation:** with `out_valid` = 1 and `out_ready` = 0, assert `rst` for one cycle. Expect `out_valid` = 0, `out_data` = 0, `in_ready` = 0 during reset, and the next MODE 1 grant to go to channel 0.
